pipe_stage_ctrl: RTL and testbench

Sequencing controller for a linear chain of enable-gated pipeline register banks. Generates per-stage write enables and valid bits for each register bank, and propagates downstream stalls backward with bubble collapse. Handles partial flushes, such as a branch mispredict, followed by a fixed refill holdoff. Sits between the fetch source, the per-stage hazard logic and the retire sink.

---
 rtl/pipe_stage_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - pipeline stage enable/valid sequencer with stall collapse and flush refill
// Optional: define PIPE_STAGE_CTRL_PERF_EN to add the stall_cnt output.
module pipe_stage_ctrl #(
    parameter int STAGES     = 4,
    parameter int REFILL_CYC = 2,
    parameter int SW         = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [STAGES-1:0] stall_req,
    input  logic              out_rdy,
    output logic              out_vld,
    input  logic              flush,
    input  logic [SW-1:0]     flush_upto,
    output logic [STAGES-1:0] wrt_en,
    output logic [STAGES-1:0] stg_vld,
    output logic              busy
`ifdef PIPE_STAGE_CTRL_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int CW = 4;

    typedef enum logic {
        RUN    = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [STAGES-1:0] stg_vld_q, stg_vld_d;
    logic [STAGES:0]   acc;
    logic [STAGES-1:0] adv;
    logic [31:0]       fu_ext;

    // Ready ripples backward from the sink; an empty stage always accepts.
    always_comb begin
        acc         = '0;
        adv         = '0;
        acc[STAGES] = out_rdy;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = stg_vld_q[i] & ~stall_req[i] & acc[i+1];
            acc[i] = ~stg_vld_q[i] | adv[i];
        end
    end

    assign wrt_en  = acc[STAGES-1:0];
    assign stg_vld = stg_vld_q;
    assign out_vld = stg_vld_q[STAGES-1] & ~stall_req[STAGES-1];
    assign fu_ext  = 32'(flush_upto);

    // An out-of-range flush_upto kills every stage, which equals clamping to STAGES-1.
    always_comb begin
        stg_vld_d = stg_vld_q;
        if (acc[0]) begin
            stg_vld_d[0] = in_vld & in_rdy;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (acc[i]) begin
                stg_vld_d[i] = adv[i-1];
            end
        end
        if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                if (fu_ext >= 32'(i)) begin
                    stg_vld_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            stg_vld_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stg_vld_q <= stg_vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = REFILL;
                    cnt_d   = CW'(REFILL_CYC - 1);
                end
            end
            REFILL: begin
                if (flush) begin
                    cnt_d = CW'(REFILL_CYC - 1);
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == REFILL);
        in_rdy = acc[0] & (state_q == RUN);
    end

`ifdef PIPE_STAGE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stg_vld_q[0] && !acc[0] && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - directed self-checking bench for pipe_stage_ctrl (STAGES=4, REFILL_CYC=2)
module tb_pipe_stage_ctrl;

    logic       clk;
    logic       rst;
    logic       in_vld;
    logic       in_rdy;
    logic [3:0] stall_req;
    logic       out_rdy;
    logic       out_vld;
    logic       flush;
    logic [1:0] flush_upto;
    logic [3:0] wrt_en;
    logic [3:0] stg_vld;
    logic       busy;
`ifdef PIPE_STAGE_CTRL_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int n_cmp;
    int n_bad;

    pipe_stage_ctrl #(
        .STAGES     (4),
        .REFILL_CYC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .stall_req  (stall_req),
        .out_rdy    (out_rdy),
        .out_vld    (out_vld),
        .flush      (flush),
        .flush_upto (flush_upto),
        .wrt_en     (wrt_en),
        .stg_vld    (stg_vld),
        .busy       (busy)
`ifdef PIPE_STAGE_CTRL_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        in_vld     = 1'b0;
        stall_req  = 4'b0000;
        out_rdy    = 1'b1;
        flush      = 1'b0;
        flush_upto = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_stg_vld", 32'(stg_vld), 32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_out_vld", 32'(out_vld), 32'h0);
        check("rst_wrt_en",  32'(wrt_en),  32'hF);
        check("rst_in_rdy",  32'(in_rdy),  32'h1);

        // Streaming: first accept now, out_vld from the 4th cycle on.
        in_vld = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] exp_v;
            exp_v = (k >= 4) ? 4'b1111 : 4'((1 << k) - 1);
            check($sformatf("strm_wrt_en_%0d", k),  32'(wrt_en),  32'hF);
            check($sformatf("strm_in_rdy_%0d", k),  32'(in_rdy),  32'h1);
            check($sformatf("strm_out_vld_%0d", k), 32'(out_vld), (k >= 4) ? 32'h1 : 32'h0);
            check($sformatf("strm_stg_vld_%0d", k), 32'(stg_vld), 32'(exp_v));
            tick();
        end

        // Mid stall on stage 2: stages 0..2 hold, stage 3 drains.
        stall_req = 4'b0100;
        #1;
        check("stall_out_vld_0", 32'(out_vld), 32'h1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall_wrt_en_%0d", k), 32'(wrt_en), 32'h8);
            check($sformatf("stall_in_rdy_%0d", k), 32'(in_rdy), 32'h0);
            tick();
            check($sformatf("stall_stg_vld_%0d", k), 32'(stg_vld), 32'h7);
        end
        check("stall_out_vld_end", 32'(out_vld), 32'h0);
        stall_req = 4'b0000;
        tick();
        check("unstall_stg_vld", 32'(stg_vld), 32'hF);

        // Flush stages 0..1 from a full pipe; concurrent accepted item is dropped.
        flush      = 1'b1;
        flush_upto = 2'd1;
        #1;
        check("fl_in_rdy_t", 32'(in_rdy), 32'h1);
        tick();
        flush = 1'b0;
        check("fl_stg_vld_t1", 32'(stg_vld), 32'hC);
        check("fl_busy_t1",    32'(busy),    32'h1);
        check("fl_in_rdy_t1",  32'(in_rdy),  32'h0);
        tick();
        check("fl_stg_vld_t2", 32'(stg_vld), 32'h8);
        check("fl_busy_t2",    32'(busy),    32'h1);
        check("fl_in_rdy_t2",  32'(in_rdy),  32'h0);
        flush      = 1'b1;
        flush_upto = 2'd0;
        tick();
        flush = 1'b0;
        check("refl_stg_vld_t3", 32'(stg_vld), 32'h0);
        check("refl_busy_t3",    32'(busy),    32'h1);
        check("refl_in_rdy_t3",  32'(in_rdy),  32'h0);
        tick();
        check("refl_busy_t4",   32'(busy),   32'h1);
        check("refl_in_rdy_t4", 32'(in_rdy), 32'h0);
        tick();
        check("refl_busy_t5",   32'(busy),   32'h0);
        check("refl_in_rdy_t5", 32'(in_rdy), 32'h1);

        // Build stg_vld=1010 then block the sink to show bubble collapse.
        in_vld = 1'b0;
        tick();
        check("pre_bub_empty", 32'(stg_vld), 32'h0);
        in_vld = 1'b1; tick();
        in_vld = 1'b0; tick();
        in_vld = 1'b1; tick();
        in_vld = 1'b0; tick();
        check("bub_stg_vld_0", 32'(stg_vld), 32'hA);
        out_rdy = 1'b0;
        #1;
        check("bub_wrt_en_0",  32'(wrt_en),  32'h7);
        check("bub_out_vld_0", 32'(out_vld), 32'h1);
        check("bub_in_rdy_0",  32'(in_rdy),  32'h1);
        tick();
        check("bub_stg_vld_1", 32'(stg_vld), 32'hC);
        check("bub_wrt_en_1",  32'(wrt_en),  32'h3);
        tick();
        check("bub_stg_vld_2", 32'(stg_vld), 32'hC);

        // Reset with a full pipe and a concurrent flush.
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("full_stg_vld", 32'(stg_vld), 32'hF);
        rst        = 1'b1;
        flush      = 1'b1;
        flush_upto = 2'd3;
        tick();
        rst    = 1'b0;
        flush  = 1'b0;
        in_vld = 1'b0;
        #1;
        check("rstm_stg_vld", 32'(stg_vld), 32'h0);
        check("rstm_busy",    32'(busy),    32'h0);
        check("rstm_in_rdy",  32'(in_rdy),  32'h1);

`ifdef PIPE_STAGE_CTRL_PERF_EN
        check("perf_after_rst", 32'(stall_cnt), 32'h0);
        in_vld    = 1'b1;
        stall_req = 4'b0001;
        tick();
        for (int k = 0; k < 3; k++) tick();
        check("perf_cnt_3", 32'(stall_cnt), 32'h3);
        for (int k = 0; k < 70000; k++) tick();
        check("perf_sat", 32'(stall_cnt), 32'hFFFF);
        flush      = 1'b1;
        flush_upto = 2'd3;
        tick();
        flush = 1'b0;
        check("perf_flush_keep", 32'(stall_cnt), 32'hFFFF);
        stall_req = 4'b0000;
        in_vld    = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
